// File: rtl/poly_taps_loader_if.sv
// Tap write bus and DSP tap-programming port for poly_taps_loader.
//   tap_wr_addr/tap_wr_data/tap_wr_en : shadow bank write strobe (master -> slave)
//   taps_prog_dout/_valid             : tap stream to the DSP (slave -> master)
//   taps_prog_dout_ready              : DSP accepts the current tap (master -> slave)
//   taps_prog_done                    : DSP reports all taps loaded (master -> slave)
interface poly_taps_loader_if;
  logic [7:0]  tap_wr_addr;
  logic [31:0] tap_wr_data;
  logic        tap_wr_en;
  logic [31:0] taps_prog_dout;
  logic        taps_prog_dout_valid;
  logic        taps_prog_dout_ready;
  logic        taps_prog_done;

  // Loader side.
  modport slave (
    input  tap_wr_addr, tap_wr_data, tap_wr_en,
    input  taps_prog_dout_ready, taps_prog_done,
    output taps_prog_dout, taps_prog_dout_valid
  );

  // Host / DSP side.
  modport master (
    output tap_wr_addr, tap_wr_data, tap_wr_en,
    output taps_prog_dout_ready, taps_prog_done,
    input  taps_prog_dout, taps_prog_dout_valid
  );
endinterface

// File: rtl/poly_taps_loader.sv
// Shadow bank of N = G_POLY_ORDER+1 single-precision taps, streamed to a DSP
// tap port on request with valid/ready, then waits (bounded) for the DSP's
// done report.
//   clk, reset (async, active-low)
//   enable     : synchronous soft clear when low (bank is kept)
//   start      : one-cycle request to stream all taps
//   bus        : write bus + DSP tap port (slave modport)
//   busy       : STREAM or WAIT_DONE
//   load_done  : DONE state
//   load_error : ERROR state (done timeout)
//   wr_reject  : one-cycle pulse after a discarded write
module poly_taps_loader #(
  parameter int unsigned G_POLY_ORDER   = 5,
  parameter int unsigned G_DONE_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                start,
  poly_taps_loader_if.slave   bus,
  output logic                busy,
  output logic                load_done,
  output logic                load_error,
  output logic                wr_reject
);

  localparam int unsigned N     = G_POLY_ORDER + 1;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CNT_W = (G_DONE_TIMEOUT > 1) ? $clog2(G_DONE_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STREAM,
    S_WAIT_DONE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state;
  logic [31:0]       bank [N];
  logic [IDX_W-1:0]  index;
  logic [CNT_W-1:0]  cnt;

  logic              idle_like_c;
  logic              wr_ok_c;
  logic [31:0]       tap0_c;
  logic [IDX_W-1:0]  index_inc_c;
  logic [CNT_W-1:0]  cnt_inc_c;

  // Writes are only accepted while no stream is in progress.
  assign idle_like_c = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);
  assign wr_ok_c     = bus.tap_wr_en && (32'(bus.tap_wr_addr) < N) && idle_like_c;

  // Bypass so a write coinciding with start streams the new tap 0.
  assign tap0_c      = (wr_ok_c && (bus.tap_wr_addr == 8'd0)) ? bus.tap_wr_data : bank[0];

  assign index_inc_c = index + IDX_W'(1);
  assign cnt_inc_c   = cnt + CNT_W'(1);

  // Bank, FSM and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                    <= S_IDLE;
      for (int i = 0; i < int'(N); i++) bank[i] <= '0;
      index                    <= '0;
      cnt                      <= '0;
      bus.taps_prog_dout       <= '0;
      bus.taps_prog_dout_valid <= 1'b0;
      busy                     <= 1'b0;
      load_done                <= 1'b0;
      load_error               <= 1'b0;
      wr_reject                <= 1'b0;
    end else begin
      wr_reject <= bus.tap_wr_en && !wr_ok_c;
      if (wr_ok_c) bank[bus.tap_wr_addr[IDX_W-1:0]] <= bus.tap_wr_data;

      if (!enable) begin
        state                    <= S_IDLE;
        index                    <= '0;
        cnt                      <= '0;
        bus.taps_prog_dout       <= '0;
        bus.taps_prog_dout_valid <= 1'b0;
        busy                     <= 1'b0;
        load_done                <= 1'b0;
        load_error               <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
              state                    <= S_STREAM;
              index                    <= '0;
              bus.taps_prog_dout       <= tap0_c;
              bus.taps_prog_dout_valid <= 1'b1;
              busy                     <= 1'b1;
              load_done                <= 1'b0;
              load_error               <= 1'b0;
            end
          end

          S_STREAM: begin
            if (bus.taps_prog_dout_valid && bus.taps_prog_dout_ready) begin
              if (index == IDX_W'(N - 1)) begin
                state                    <= S_WAIT_DONE;
                cnt                      <= '0;
                bus.taps_prog_dout_valid <= 1'b0;
              end else begin
                index              <= index_inc_c;
                bus.taps_prog_dout <= bank[index_inc_c];
              end
            end
          end

          S_WAIT_DONE: begin
            // Done is checked first so it wins on the timeout cycle.
            if (bus.taps_prog_done) begin
              state     <= S_DONE;
              busy      <= 1'b0;
              load_done <= 1'b1;
            end else if (cnt_inc_c == CNT_W'(G_DONE_TIMEOUT)) begin
              state      <= S_ERROR;
              cnt        <= cnt_inc_c;
              busy       <= 1'b0;
              load_error <= 1'b1;
            end else begin
              cnt <= cnt_inc_c;
            end
          end

          default: begin
            state                    <= S_IDLE;
            bus.taps_prog_dout_valid <= 1'b0;
            busy                     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_poly_taps_loader.sv
// Directed bench for poly_taps_loader with a tap scoreboard.
module tb_poly_taps_loader;

  logic clk    = 1'b0;
  logic reset  = 1'b0;
  logic enable = 1'b0;
  logic start  = 1'b0;
  logic busy, load_done, load_error, wr_reject;

  poly_taps_loader_if bus ();

  poly_taps_loader #(.G_POLY_ORDER(5), .G_DONE_TIMEOUT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .start      (start),
    .bus        (bus.slave),
    .busy       (busy),
    .load_done  (load_done),
    .load_error (load_error),
    .wr_reject  (wr_reject)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          ntaps = 0;
  logic [31:0] sb [$];
  logic [31:0] model [6];
  logic        hold_pend = 1'b0;
  logic [31:0] hold_val  = '0;
  logic [3:0]  pat = 4'b1001;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // One clock: monitor the tap port at negedge, return 1 time unit after posedge.
  task automatic cycle();
    @(negedge clk);
    if (hold_pend) begin
      chk("hold_valid", 32'(bus.taps_prog_dout_valid), 32'd1);
      chk("hold_data", bus.taps_prog_dout, hold_val);
    end
    hold_pend = 1'b0;
    if (bus.taps_prog_dout_valid && bus.taps_prog_dout_ready) begin
      ntaps++;
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) chk("tap", bus.taps_prog_dout, sb.pop_front());
    end else if (bus.taps_prog_dout_valid) begin
      hold_pend = 1'b1;
      hold_val  = bus.taps_prog_dout;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] d, input logic rej);
    bus.tap_wr_addr = 8'(a);
    bus.tap_wr_data = d;
    bus.tap_wr_en   = 1'b1;
    cycle();
    bus.tap_wr_en   = 1'b0;
    chk("wr_reject", 32'(wr_reject), 32'(rej));
    if (!rej) model[a] = d;
  endtask

  task automatic begin_load();
    ntaps = 0;
    for (int i = 0; i < 6; i++) sb.push_back(model[i]);
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic finish_load(input int bound, input bit toggle);
    for (int j = 0; j < bound && !load_done; j++) begin
      bus.taps_prog_dout_ready = toggle ? pat[j % 4] : 1'b1;
      cycle();
    end
    bus.taps_prog_dout_ready = 1'b1;
    chk("load_done_reached", 32'(load_done), 32'd1);
    chk("tap_count", 32'(ntaps), 32'd6);
    chk("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_wait_done();
    for (int j = 0; j < 40 && !(busy && !bus.taps_prog_dout_valid); j++) cycle();
    chk("wait_done_entered", 32'(busy && !bus.taps_prog_dout_valid), 32'd1);
  endtask

  initial begin
    logic [31:0] vals [6];
    vals = '{32'h3F800000, 32'h40000000, 32'h40400000,
             32'h40800000, 32'h40A00000, 32'h40C00000};
    bus.tap_wr_addr          = '0;
    bus.tap_wr_data          = '0;
    bus.tap_wr_en            = 1'b0;
    bus.taps_prog_dout_ready = 1'b0;
    bus.taps_prog_done       = 1'b0;
    for (int i = 0; i < 6; i++) model[i] = '0;

    // Reset state.
    #23;
    chk("rst_dout", bus.taps_prog_dout, 32'h0);
    chk("rst_valid", 32'(bus.taps_prog_dout_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_load_error", 32'(load_error), 32'd0);
    chk("rst_wr_reject", 32'(wr_reject), 32'd0);
    @(posedge clk); #1;
    reset  = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    chk("idle_after_reset", 32'(busy), 32'd0);

    // Basic load: latency with done raised in WAIT_DONE.
    for (int i = 0; i < 6; i++) wr(i, vals[i], 1'b0);
    bus.taps_prog_dout_ready = 1'b1;
    ntaps = 0;
    for (int i = 0; i < 6; i++) sb.push_back(model[i]);
    start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      start = 1'b0;
      chk($sformatf("latency_load_done_k%0d", k), 32'(load_done), 32'(k == 8));
      if (busy && !bus.taps_prog_dout_valid) bus.taps_prog_done = 1'b1;
    end
    chk("basic_tap_count", 32'(ntaps), 32'd6);
    chk("basic_sb_empty", 32'(sb.size()), 32'd0);
    chk("basic_busy_low", 32'(busy), 32'd0);

    // Ready toggling 1,0,0,1; done held high (ignored until WAIT_DONE).
    begin_load();
    finish_load(60, 1'b1);

    // Done timeout, then restart from tap 0.
    bus.taps_prog_done = 1'b0;
    begin_load();
    wait_wait_done();
    for (int j = 1; j <= 16; j++) begin
      cycle();
      chk($sformatf("timeout_err_j%0d", j), 32'(load_error), 32'(j == 16));
    end
    chk("timeout_valid", 32'(bus.taps_prog_dout_valid), 32'd0);
    chk("timeout_busy", 32'(busy), 32'd0);
    bus.taps_prog_done = 1'b1;
    begin_load();
    finish_load(20, 1'b0);

    // Done on the timeout cycle wins.
    bus.taps_prog_done = 1'b0;
    begin_load();
    wait_wait_done();
    for (int j = 1; j <= 15; j++) cycle();
    chk("edge_no_err_yet", 32'(load_error), 32'd0);
    bus.taps_prog_done = 1'b1;
    cycle();
    chk("edge_done_wins", 32'(load_done), 32'd1);
    chk("edge_no_error", 32'(load_error), 32'd0);

    // Rejected writes: out of range, and during STREAM.
    wr(6, 32'h11111111, 1'b1);
    cycle();
    chk("wr_reject_pulse_end", 32'(wr_reject), 32'd0);
    begin_load();
    wr(2, 32'hDEADBEEF, 1'b1);
    finish_load(20, 1'b0);
    begin_load();
    finish_load(20, 1'b0);

    // Reset mid-stream after 3 accepted taps.
    bus.taps_prog_done = 1'b0;
    begin_load();
    for (int j = 0; j < 20 && ntaps < 3; j++) cycle();
    chk("three_taps", 32'(ntaps), 32'd3);
    reset = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(bus.taps_prog_dout_valid), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    sb.delete();
    hold_pend = 1'b0;
    for (int i = 0; i < 6; i++) model[i] = '0;
    cycle();
    cycle();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    chk("post_rst_idle_busy", 32'(busy), 32'd0);
    chk("post_rst_idle_valid", 32'(bus.taps_prog_dout_valid), 32'd0);
    bus.taps_prog_done = 1'b1;
    begin_load();
    finish_load(20, 1'b0);

    // Soft clear during WAIT_DONE keeps the bank.
    for (int i = 0; i < 6; i++) wr(i, 32'hA0000000 + 32'(i), 1'b0);
    bus.taps_prog_done = 1'b0;
    begin_load();
    wait_wait_done();
    enable = 1'b0;
    cycle();
    enable = 1'b1;
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_valid", 32'(bus.taps_prog_dout_valid), 32'd0);
    chk("clr_error", 32'(load_error), 32'd0);
    cycle();
    chk("clr_stays_idle", 32'(busy), 32'd0);
    bus.taps_prog_done = 1'b1;
    begin_load();
    finish_load(20, 1'b0);

    // Write to tap 0 together with start in IDLE streams the new value.
    enable = 1'b0;
    cycle();
    enable = 1'b1;
    model[0] = 32'h3F000000;
    ntaps = 0;
    for (int i = 0; i < 6; i++) sb.push_back(model[i]);
    bus.tap_wr_addr = 8'd0;
    bus.tap_wr_data = 32'h3F000000;
    bus.tap_wr_en   = 1'b1;
    start           = 1'b1;
    cycle();
    bus.tap_wr_en   = 1'b0;
    start           = 1'b0;
    chk("wr_start_no_reject", 32'(wr_reject), 32'd0);
    finish_load(20, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
